// File: rtl/arcino_rf_pkg.sv
// arcino_rf_pkg
// Shared types and helpers for the ARCINO multi-port register file:
//   rf_addr_t       5-bit architectural register address
//   rf_clr_state_e  clear engine states (IDLE, CLEAR, DONE)
//   rf_addr_legal   address legality check for RV32I / RV32E
package arcino_rf_pkg;

  localparam int unsigned ADDR_WIDTH_I = 5;
  localparam int unsigned ADDR_WIDTH_E = 4;
  localparam int unsigned NUM_WORDS_I  = 32;
  localparam int unsigned NUM_WORDS_E  = 16;

  typedef logic [4:0] rf_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } rf_clr_state_e;

  // RV32E only implements x0..x15; anything with bit 4 set does not exist.
  function automatic logic rf_addr_legal(rf_addr_t addr, logic rv32e);
    return !(rv32e && addr[4]);
  endfunction

endpackage

// File: rtl/arcino_rf_scoreboard.sv
// arcino_rf_scoreboard
// Per-register pending-write bits for long-latency producers.
//   clk_i, rst_ni  clock, async active-low reset
//   clear_all_i    drop every pending bit at the next edge
//   rsv_i          mark rsv_addr_i pending (already qualified by the top)
//   we_i, waddr_i  qualified write enables / truncated addresses per port
//   busy_o         registered pending vector, bit 0 always 0
module arcino_rf_scoreboard
  import arcino_rf_pkg::*;
#(
  parameter int unsigned AddrWidth = ADDR_WIDTH_I,
  parameter int unsigned NumWords  = NUM_WORDS_I,
  parameter int unsigned NumWrite  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_all_i,
  input  logic                          rsv_i,
  input  logic [AddrWidth-1:0]          rsv_addr_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic [NumWrite*AddrWidth-1:0] waddr_i,
  output logic [NumWords-1:0]           busy_o
);

  logic [NumWords-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < NumWrite; j++) begin
      if (we_i[j]) busy_d[waddr_i[j*AddrWidth +: AddrWidth]] = 1'b0;
    end
    // A reserve issued alongside a completing write belongs to a newer
    // producer, so the set is applied after the clears.
    if (rsv_i) busy_d[rsv_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
    if (clear_all_i) busy_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/arcino_register_file_mp.sv
// arcino_register_file_mp
// Multi-port flip-flop register file with optional write bypass, pending-write
// scoreboard and a sequential clear engine. R0 reads as zero.
//   clk_i, rst_ni            clock, async active-low reset
//   test_en_i                disables write-to-read bypass
//   raddr_i/rdata_o/rbusy_o  NumRead combinational read ports (5-bit addr each)
//   waddr_i/wdata_i/we_i     NumWrite write ports, higher index wins
//   rsv_i, rsv_addr_i        reserve a destination in the scoreboard
//   clear_req_i              start zeroing x1..x(N-1)
//   clear_busy_o             high while registers are being cleared
//   clear_done_o             one-cycle pulse after the last register is cleared
module arcino_register_file_mp
  import arcino_rf_pkg::*;
#(
  parameter bit          RV32E       = 1'b0,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned NumRead     = 2,
  parameter int unsigned NumWrite    = 2,
  parameter bit          WriteBypass = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          test_en_i,
  input  logic [NumRead*5-1:0]          raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rbusy_o,
  input  logic [NumWrite*5-1:0]         waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          rsv_i,
  input  logic [4:0]                    rsv_addr_i,
  input  logic                          clear_req_i,
  output logic                          clear_busy_o,
  output logic                          clear_done_o
);

  localparam int unsigned AW = RV32E ? ADDR_WIDTH_E : ADDR_WIDTH_I;
  localparam int unsigned NW = RV32E ? NUM_WORDS_E : NUM_WORDS_I;

  logic [DataWidth-1:0] regs_q [NW];
  rf_clr_state_e        state_q;
  logic [AW-1:0]        cnt_q;
  logic                 clear_busy_q, clear_done_q;

  rf_addr_t             waddr_a [NumWrite];
  logic [NumWrite-1:0]  we_eff;
  logic [NumWrite*AW-1:0] sb_waddr;
  logic                 rsv_eff;
  logic                 clear_start;
  logic                 bypass_en;
  logic [NW-1:0]        busy;

  // Writes and reserves are suppressed while the clear engine owns the array,
  // and never reach R0 or a nonexistent RV32E register.
  for (genvar gj = 0; gj < NumWrite; gj++) begin : g_wr
    assign waddr_a[gj] = waddr_i[gj*5 +: 5];
    assign we_eff[gj]  = we_i[gj] && !clear_busy_q &&
                         rf_addr_legal(waddr_a[gj], RV32E) && (waddr_a[gj] != '0);
    assign sb_waddr[gj*AW +: AW] = waddr_a[gj][AW-1:0];
  end

  assign rsv_eff     = rsv_i && !clear_busy_q &&
                       rf_addr_legal(rsv_addr_i, RV32E) && (rsv_addr_i != '0);
  assign clear_start = (state_q == IDLE) && clear_req_i;
  assign bypass_en   = WriteBypass && !test_en_i;

  arcino_rf_scoreboard #(
    .AddrWidth (AW),
    .NumWords  (NW),
    .NumWrite  (NumWrite)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_all_i (clear_start),
    .rsv_i       (rsv_eff),
    .rsv_addr_i  (rsv_addr_i[AW-1:0]),
    .we_i        (we_eff),
    .waddr_i     (sb_waddr),
    .busy_o      (busy)
  );

  // Clear engine: R0 is never stored, so the sweep starts at 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clear_done_q <= 1'b0;
          if (clear_req_i) begin
            state_q      <= CLEAR;
            cnt_q        <= AW'(1);
            clear_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NW-1)) begin
            state_q      <= DONE;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          clear_done_q <= 1'b0;
        end
        default: begin
          state_q      <= IDLE;
          clear_busy_q <= 1'b0;
          clear_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Later ports overwrite earlier ones through NBA ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NW; r++) regs_q[r] <= '0;
    end else begin
      if (state_q == CLEAR) regs_q[cnt_q] <= '0;
      for (int j = 0; j < NumWrite; j++) begin
        if (we_eff[j]) regs_q[waddr_a[j][AW-1:0]] <= wdata_i[j*DataWidth +: DataWidth];
      end
    end
  end

  for (genvar gi = 0; gi < NumRead; gi++) begin : g_rd
    rf_addr_t             ra;
    logic [DataWidth-1:0] rd;
    logic                 rb;

    assign ra = raddr_i[gi*5 +: 5];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (rf_addr_legal(ra, RV32E) && (ra != '0)) begin
        rd = regs_q[ra[AW-1:0]];
        rb = busy[ra[AW-1:0]];
      end
      // we_eff already excludes R0 and illegal addresses.
      if (bypass_en) begin
        for (int j = 0; j < NumWrite; j++) begin
          if (we_eff[j] && (waddr_a[j] == ra)) rd = wdata_i[j*DataWidth +: DataWidth];
        end
      end
    end

    assign rdata_o[gi*DataWidth +: DataWidth] = rd;
    assign rbusy_o[gi] = rb;
  end

  assign clear_busy_o = clear_busy_q;
  assign clear_done_o = clear_done_q;

endmodule

// File: tb/tb_arcino_register_file_mp.sv
// tb_arcino_register_file_mp
// Directed bench: table-driven port vectors on an RV32I instance, plus
// sequences for clear, RV32E legality/clear and reset during a clear.
module tb_arcino_register_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // RV32I instance
  logic        test_en;
  logic [4:0]  ra0, ra1, wa0, wa1, rsv_addr;
  logic [31:0] wd0, wd1;
  logic [1:0]  we;
  logic        rsv, clear_req;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        clear_busy, clear_done;

  // RV32E instance
  logic [4:0]  ra0_e, ra1_e, wa0_e, wa1_e, rsv_addr_e;
  logic [31:0] wd0_e, wd1_e;
  logic [1:0]  we_e;
  logic        rsv_e, clear_req_e;
  logic [63:0] rdata_e;
  logic [1:0]  rbusy_e;
  logic        clear_busy_e, clear_done_e;

  arcino_register_file_mp #(.RV32E(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_i({ra1, ra0}), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_i({wa1, wa0}), .wdata_i({wd1, wd0}), .we_i(we),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr), .clear_req_i(clear_req),
    .clear_busy_o(clear_busy), .clear_done_o(clear_done)
  );

  arcino_register_file_mp #(.RV32E(1'b1)) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en),
    .raddr_i({ra1_e, ra0_e}), .rdata_o(rdata_e), .rbusy_o(rbusy_e),
    .waddr_i({wa1_e, wa0_e}), .wdata_i({wd1_e, wd0_e}), .we_i(we_e),
    .rsv_i(rsv_e), .rsv_addr_i(rsv_addr_e), .clear_req_i(clear_req_e),
    .clear_busy_o(clear_busy_e), .clear_done_o(clear_done_e)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  rsva;
    logic        te;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  function automatic vec_t mk(logic [1:0] w, logic [4:0] a0, logic [31:0] d0,
                              logic [4:0] a1, logic [31:0] d1, logic rs, logic [4:0] rsa,
                              logic t, logic [4:0] r0, logic [4:0] r1,
                              logic [31:0] x0, logic [31:0] x1, logic [1:0] b);
    vec_t v;
    v.we = w; v.wa0 = a0; v.wd0 = d0; v.wa1 = a1; v.wd1 = d1;
    v.rsv = rs; v.rsva = rsa; v.te = t; v.ra0 = r0; v.ra1 = r1;
    v.e0 = x0; v.e1 = x1; v.eb = b;
    return v;
  endfunction

  task automatic idle_inputs();
    we = 2'b00; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    rsv = 1'b0; rsv_addr = '0; clear_req = 1'b0;
    we_e = 2'b00; wa0_e = '0; wa1_e = '0; wd0_e = '0; wd1_e = '0;
    rsv_e = 1'b0; rsv_addr_e = '0; clear_req_e = 1'b0;
  endtask

  vec_t vecs [20];
  int   bcnt, dcnt;
  logic b, d;
  logic hit;

  initial begin
    vecs[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'h0, 32'h0, 2'b00);
    vecs[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 5, 5, 32'h0, 32'h0, 2'b00);
    vecs[2]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00);
    vecs[3]  = mk(2'b01, 5, 32'h12345678, 0, 0, 0, 0, 0, 5, 3, 32'h12345678, 32'h0, 2'b00);
    vecs[4]  = mk(2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 7, 5, 32'h22, 32'h12345678, 2'b00);
    vecs[5]  = mk(2'b01, 0, 32'hFFFF, 0, 0, 0, 0, 0, 7, 0, 32'h22, 32'h0, 2'b00);
    vecs[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 7, 32'h0, 32'h22, 2'b00);
    vecs[7]  = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 32'h0, 32'h0, 2'b00);
    vecs[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h0, 32'h22, 2'b01);
    vecs[9]  = mk(2'b10, 0, 0, 9, 32'h5, 0, 0, 0, 9, 7, 32'h5, 32'h22, 2'b01);
    vecs[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 7, 32'h5, 32'h22, 2'b00);
    vecs[11] = mk(2'b01, 9, 32'h6, 0, 0, 1, 9, 0, 9, 9, 32'h6, 32'h6, 2'b00);
    vecs[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h6, 32'h6, 2'b11);
    vecs[13] = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 32'h6, 32'h6, 2'b11);
    vecs[14] = mk(2'b11, 9, 32'h7, 10, 32'h8, 0, 0, 0, 9, 10, 32'h7, 32'h8, 2'b01);
    vecs[15] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 10, 32'h7, 32'h8, 2'b00);
    vecs[16] = mk(2'b11, 11, 32'h44, 11, 32'h33, 0, 0, 1, 11, 11, 32'h0, 32'h0, 2'b00);
    vecs[17] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 11, 5, 32'h33, 32'h12345678, 2'b00);
    vecs[18] = mk(2'b11, 12, 32'hA, 12, 32'hB, 0, 0, 0, 12, 0, 32'hB, 32'h0, 2'b00);
    vecs[19] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 12, 32'hB, 32'hB, 2'b00);

    idle_inputs();
    test_en = 1'b0;
    ra0 = 5'd5; ra1 = 5'd9; ra0_e = 5'd3; ra1_e = 5'd0;

    // Reset state
    #2;
    chk("reset_rdata0", rdata[31:0], 32'h0);
    chk("reset_rdata1", rdata[63:32], 32'h0);
    chk("reset_rbusy", {30'b0, rbusy}, 32'h0);
    chk("reset_clear_busy", {31'b0, clear_busy}, 32'h0);
    chk("reset_clear_done", {31'b0, clear_done}, 32'h0);
    chk("reset_e_clear_busy", {31'b0, clear_busy_e}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Port vectors
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      we = vecs[i].we; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      rsv = vecs[i].rsv; rsv_addr = vecs[i].rsva; test_en = vecs[i].te;
      ra0 = vecs[i].ra0; ra1 = vecs[i].ra1;
      #1;
      chk($sformatf("vec%0d_rdata0", i), rdata[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_rdata1", i), rdata[63:32], vecs[i].e1);
      chk($sformatf("vec%0d_rbusy", i), {30'b0, rbusy}, {30'b0, vecs[i].eb});
    end
    @(negedge clk);
    idle_inputs();
    test_en = 1'b0;

    // Load x1..x31, reserving x12 in the same cycle it is written
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      we = 2'b01; wa0 = 5'(i); wd0 = 32'h1000 + i;
      rsv = (i == 12); rsv_addr = 5'd12;
    end
    @(negedge clk);
    idle_inputs();
    ra0 = 5'd31; ra1 = 5'd12;
    #1;
    chk("load_x31", rdata[31:0], 32'h101F);
    chk("load_x12_busy", {31'b0, rbusy[1]}, 32'h1);

    // Clear request together with a write to x3
    @(negedge clk);
    we = 2'b01; wa0 = 5'd3; wd0 = 32'hABC; clear_req = 1'b1;
    #1;
    chk("clear_start_idle_busy", {31'b0, clear_busy}, 32'h0);
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      b = clear_busy; d = clear_done;
      if (b) bcnt++;
      if (d) dcnt++;
      // Writes/reserves while busy must be ignored; re-requests must be too.
      we = {1'b0, b}; wa0 = 5'd2; wd0 = 32'hBAD;
      rsv = b; rsv_addr = 5'd13;
      clear_req = (bcnt == 5) || d;
      ra0 = 5'd3; ra1 = 5'd2;
      #1;
      if (b && bcnt == 1) begin
        chk("clear_x3_write_committed", rdata[31:0], 32'hABC);
        chk("clear_x2_old_no_bypass", rdata[63:32], 32'h1002);
        chk("clear_scoreboard_cleared", {31'b0, rbusy[1]}, 32'h0);
      end
    end
    chk("clear_busy_cycles", bcnt, 32'd31);
    chk("clear_done_pulses", dcnt, 32'd1);
    idle_inputs();
    for (int r = 0; r < 32; r++) begin
      ra0 = 5'(r); ra1 = 5'(31 - r);
      #1;
      chk($sformatf("cleared_x%0d", r), rdata[31:0], 32'h0);
      if (r == 12 || r == 13) chk($sformatf("cleared_busy_x%0d", r), {31'b0, rbusy[0]}, 32'h0);
    end

    // RV32E: illegal addresses dropped, aliasing not allowed
    @(negedge clk);
    we_e = 2'b01; wa0_e = 5'd20; wd0_e = 32'hAA; ra0_e = 5'd20; ra1_e = 5'd4;
    #1;
    chk("e_x20_bypass", rdata_e[31:0], 32'h0);
    @(negedge clk);
    we_e = 2'b01; wa0_e = 5'd4; wd0_e = 32'h44; rsv_e = 1'b1; rsv_addr_e = 5'd20;
    #1;
    chk("e_x20_read", rdata_e[31:0], 32'h0);
    chk("e_x4_bypass", rdata_e[63:32], 32'h44);
    @(negedge clk);
    we_e = 2'b00; rsv_e = 1'b0;
    #1;
    chk("e_x20_read2", rdata_e[31:0], 32'h0);
    chk("e_x20_busy", {31'b0, rbusy_e[0]}, 32'h0);
    chk("e_x4_read", rdata_e[63:32], 32'h44);
    chk("e_x4_busy", {31'b0, rbusy_e[1]}, 32'h0);
    @(negedge clk);
    clear_req_e = 1'b1;
    bcnt = 0; dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      clear_req_e = 1'b0;
      #1;
      if (clear_busy_e) bcnt++;
      if (clear_done_e) dcnt++;
    end
    chk("e_clear_busy_cycles", bcnt, 32'd15);
    chk("e_clear_done_pulses", dcnt, 32'd1);
    #1;
    chk("e_x4_cleared", rdata_e[63:32], 32'h0);

    // Reset in the 10th CLEAR cycle
    @(negedge clk);
    we = 2'b01; wa0 = 5'd20; wd0 = 32'h2020;
    @(negedge clk);
    we = 2'b00; clear_req = 1'b1; ra0 = 5'd20; ra1 = 5'd20;
    bcnt = 0; hit = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      if (!hit && clear_busy) begin
        bcnt++;
        if (bcnt == 10) begin
          hit = 1'b1;
          chk("midclear_x20_old", rdata[31:0], 32'h2020);
          #1;
          rst_n = 1'b0;
          #1;
          chk("midclear_rst_busy", {31'b0, clear_busy}, 32'h0);
          chk("midclear_rst_done", {31'b0, clear_done}, 32'h0);
          chk("midclear_rst_x20", rdata[31:0], 32'h0);
          chk("midclear_rst_rbusy", {30'b0, rbusy}, 32'h0);
        end
      end
    end
    chk("midclear_reached", {31'b0, hit}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0; bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (clear_done) dcnt++;
      if (clear_busy) bcnt++;
    end
    chk("midclear_no_done", dcnt, 32'd0);
    chk("midclear_stays_idle", bcnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
